// File: rtl/instr_fetch_pkg.sv
// Shared fetch-stage definitions: FSM states, PC type, bundle layout.
// Operand detection helper used by the fetch FSM.
package instr_fetch_pkg;

  localparam int PC_W = 8;

  typedef logic [PC_W-1:0] pc_t;

  localparam pc_t RESET_PC_DEF     = 8'h00;
  localparam pc_t OPERAND_MASK_DEF = 8'h08;

  typedef enum logic [1:0] {
    F_OP  = 2'd0,
    W_OP  = 2'd1,
    W_ARG = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef struct packed {
    logic [7:0] inst;
    logic [7:0] operand;
    logic       has_op;
    pc_t        pc;
  } bundle_t;

  function automatic logic has_op(
    input logic [7:0] op,
    input logic [7:0] mask
  );
    return |(op & mask);
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: ROM read port plus the instruction bundle handshake.
// master = fetch stage, slave = ROM / control unit side.
interface instr_fetch_if;
  import instr_fetch_pkg::*;

  pc_t        o_Addr;
  logic [7:0] i_Data;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_inst;
  logic [7:0] o_operand;
  logic       o_has_op;
  pc_t        o_pc;
  logic       i_jmp;
  pc_t        i_jmp_addr;

  modport master (
    output o_Addr,
    input  i_Data,
    output o_valid,
    input  i_ready,
    output o_inst,
    output o_operand,
    output o_has_op,
    output o_pc,
    input  i_jmp,
    input  i_jmp_addr
  );

  modport slave (
    input  o_Addr,
    output i_Data,
    input  o_valid,
    output i_ready,
    input  o_inst,
    input  o_operand,
    input  o_has_op,
    input  o_pc,
    output i_jmp,
    output i_jmp_addr
  );

endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, reads opcode (+ operand) from the ROM and
// presents the bundle through valid/ready; redirects on accepted jumps.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter pc_t        RESET_PC     = RESET_PC_DEF,
  parameter logic [7:0] OPERAND_MASK = OPERAND_MASK_DEF
) (
  input  logic          clk,
  input  logic          rst,
  instr_fetch_if.master bus
);

  state_e  state, state_n;
  pc_t     pc, pc_n;
  logic    valid, valid_n;
  bundle_t b, b_n;
  logic    xfer;
  logic    op_hit;

  assign xfer   = valid & bus.i_ready;
  assign op_hit = has_op(bus.i_Data, OPERAND_MASK);

  always_comb begin
    state_n = state;
    pc_n    = pc;
    valid_n = valid;
    b_n     = b;
    unique case (state)
      F_OP: begin
        b_n.pc  = pc;
        pc_n    = pc + 8'd1;
        state_n = W_OP;
      end
      W_OP: begin
        b_n.inst   = bus.i_Data;
        b_n.has_op = op_hit;
        if (op_hit) begin
          pc_n    = pc + 8'd1;
          state_n = W_ARG;
        end else begin
          b_n.operand = 8'h00;
          valid_n     = 1'b1;
          state_n     = HOLD;
        end
      end
      W_ARG: begin
        b_n.operand = bus.i_Data;
        valid_n     = 1'b1;
        state_n     = HOLD;
      end
      HOLD: begin
        // The next opcode read overlaps the accepting cycle
        if (xfer) begin
          valid_n = 1'b0;
          if (bus.i_jmp) begin
            pc_n    = bus.i_jmp_addr;
            state_n = F_OP;
          end else begin
            b_n.pc  = pc;
            pc_n    = pc + 8'd1;
            state_n = W_OP;
          end
        end
      end
      default: state_n = F_OP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= F_OP;
      pc    <= RESET_PC;
      valid <= 1'b0;
      b     <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      valid <= valid_n;
      b     <= b_n;
    end
  end

  assign bus.o_Addr    = pc;
  assign bus.o_valid   = valid;
  assign bus.o_inst    = b.inst;
  assign bus.o_operand = b.operand;
  assign bus.o_has_op  = b.has_op;
  assign bus.o_pc      = b.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: ROM model, transaction-level fetch model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_instr_fetch;

  logic clk;
  logic rst;
  logic [7:0] rom [256];
  logic [7:0] rom_q;

  int checks;
  int failures;

  // transaction-level model state
  logic [7:0] mpc;
  int         since;
  bit         fop;
  bit         from_rst;
  bit         started;

  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC     (8'h00),
    .OPERAND_MASK (8'h08)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[bus.o_Addr];
  assign bus.i_Data = rom_q;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic bit hop_at(input logic [7:0] a);
    return (rom[a] & 8'h08) != 8'h00;
  endfunction

  // Compare current outputs with the model, then advance the model
  // for the edge that follows.
  task automatic check_cycle();
    bit         h;
    int         gap;
    bit         ev;
    logic [7:0] nxt;
    h   = hop_at(mpc);
    gap = (fop ? 2 : 1) + int'(h);
    ev  = started && (since >= gap);
    nxt = 8'(mpc + 8'd1 + 8'(h));
    if (started) begin
      chk("m_valid", bus.o_valid, ev);
      if (since == 0)
        chk("m_addr_start", bus.o_Addr, fop ? mpc : 8'(mpc + 8'd1));
      if (since == 0 && from_rst) begin
        chk("m_rst_inst", bus.o_inst, 8'h00);
        chk("m_rst_opnd", bus.o_operand, 8'h00);
        chk("m_rst_hop", bus.o_has_op, 1'b0);
        chk("m_rst_pc", bus.o_pc, 8'h00);
      end
      if (ev) begin
        chk("m_inst", bus.o_inst, rom[mpc]);
        chk("m_hop", bus.o_has_op, h);
        chk("m_opnd", bus.o_operand, h ? rom[8'(mpc + 8'd1)] : 8'h00);
        chk("m_pc", bus.o_pc, mpc);
        chk("m_addr_hold", bus.o_Addr, nxt);
      end
    end
    if (!rst) begin
      started  = 1'b1;
      mpc      = 8'h00;
      since    = 0;
      fop      = 1'b1;
      from_rst = 1'b1;
    end else if (ev && bus.i_ready) begin
      mpc      = bus.i_jmp ? bus.i_jmp_addr : nxt;
      fop      = bus.i_jmp;
      from_rst = 1'b0;
      since    = 0;
    end else if (started) begin
      since++;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.o_valid && n < max);
    chk("valid_seen", bus.o_valid, 1'b1);
  endtask

  task automatic start_session();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;
  endtask

  task automatic end_reset();
    tick();
    rst = 1'b1;
  endtask

  int n;

  initial begin
    checks         = 0;
    failures       = 0;
    started        = 1'b0;
    mpc            = 8'h00;
    since          = 0;
    fop            = 1'b1;
    from_rst       = 1'b1;
    rst            = 1'b0;
    bus.i_ready    = 1'b1;
    bus.i_jmp      = 1'b0;
    bus.i_jmp_addr = 8'h00;
    for (int i = 0; i < 256; i++) rom[i] = 8'h00;

    // no-operand opcode after reset
    start_session();
    rom[0] = 8'h01;
    end_reset();
    chk("t1_rst_valid", bus.o_valid, 1'b0);
    chk("t1_rst_addr", bus.o_Addr, 8'h00);
    wait_valid(10, n);
    chk("t1_latency", n, 2);
    chk("t1_inst", bus.o_inst, 8'h01);
    chk("t1_hop", bus.o_has_op, 1'b0);
    chk("t1_opnd", bus.o_operand, 8'h00);
    chk("t1_pc", bus.o_pc, 8'h00);

    // operand opcode, stall in HOLD, then jump
    bus.i_ready = 1'b0;
    start_session();
    rom[0]    = 8'h08;
    rom[1]    = 8'h2A;
    rom[2]    = 8'h01;
    rom[3]    = 8'h0C;
    rom[4]    = 8'h99;
    rom[5]    = 8'h07;
    rom[8'h40] = 8'h03;
    end_reset();
    wait_valid(10, n);
    chk("t2_latency", n, 3);
    chk("t2_inst", bus.o_inst, 8'h08);
    chk("t2_opnd", bus.o_operand, 8'h2A);
    chk("t2_hop", bus.o_has_op, 1'b1);
    repeat (5) tick();
    chk("t3_valid", bus.o_valid, 1'b1);
    chk("t3_inst", bus.o_inst, 8'h08);
    chk("t3_opnd", bus.o_operand, 8'h2A);
    chk("t3_addr", bus.o_Addr, 8'h02);
    bus.i_ready = 1'b1;
    tick();
    chk("t2_valid_drop", bus.o_valid, 1'b0);
    chk("t2_next_pc", bus.o_pc, 8'h02);
    n = 0;
    while (!(bus.o_valid && bus.o_pc == 8'h05) && n < 20) begin
      tick();
      n++;
    end
    chk("t4_reach_05", bus.o_pc, 8'h05);
    bus.i_jmp      = 1'b1;
    bus.i_jmp_addr = 8'h40;
    tick();
    chk("t4_addr", bus.o_Addr, 8'h40);
    chk("t4_valid", bus.o_valid, 1'b0);
    bus.i_jmp_addr = 8'hAA;
    wait_valid(10, n);
    bus.i_jmp = 1'b0;
    chk("t4_latency", n, 2);
    chk("t4_inst", bus.o_inst, 8'h03);
    chk("t4_pc", bus.o_pc, 8'h40);
    repeat (6) tick();

    // jump to 8'hFF with operand wrapping to 8'h00
    start_session();
    rom[0]     = 8'h55;
    rom[8'hFF] = 8'h08;
    end_reset();
    wait_valid(10, n);
    chk("t5_first", bus.o_inst, 8'h55);
    bus.i_jmp      = 1'b1;
    bus.i_jmp_addr = 8'hFF;
    tick();
    bus.i_jmp = 1'b0;
    wait_valid(10, n);
    chk("t5_latency", n, 3);
    chk("t5_inst", bus.o_inst, 8'h08);
    chk("t5_opnd", bus.o_operand, 8'h55);
    chk("t5_pc", bus.o_pc, 8'hFF);
    chk("t5_addr", bus.o_Addr, 8'h01);
    repeat (4) tick();

    // reset during operand fetch
    start_session();
    rom[0] = 8'h08;
    rom[1] = 8'h2A;
    end_reset();
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("t6_valid", bus.o_valid, 1'b0);
    chk("t6_addr", bus.o_Addr, 8'h00);
    chk("t6_inst", bus.o_inst, 8'h00);
    rst = 1'b1;
    wait_valid(10, n);
    chk("t6_latency", n, 3);
    chk("t6_opnd", bus.o_operand, 8'h2A);
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout global");
    $fatal(1, "timeout");
  end

endmodule
